uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries (power of two).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wren  input  1  register write strobe, sampled on clk rising edge.
REQ-005 SHALL have port rden  input  1  register read enable.
REQ-006 SHALL have port addr  input  3  register select: 4=PERIOD, 5=TXDATA, 7=CTRL/STATUS.
REQ-007 SHALL have port din  input  8  write data.
REQ-008 SHALL have port dout  output  9  read data.
REQ-009 SHALL have port txout  output  1  serial line, idle high.

Function
REQ-010 Write addr 4 SHALL load 8-bit PERIOD; read addr 4 SHALL return {1'b0,PERIOD}.
REQ-011 dout SHALL be combinational: the selected register when rden=1, 9'h000 when rden=0 or addr unmapped.
REQ-012 Write addr 7 SHALL load TXEN from din[0]; din[7:1] ignored.
REQ-013 Read addr 7 SHALL return bit0 TXEN, bit1 TXRDY (FIFO not full), bit2 OVERRUN, bit3 TXIDLE (FIFO empty and FSM in IDLE), bits 8:4 zero.
REQ-014 Write addr 5 with TXEN=1 and FIFO not full SHALL push din; with TXEN=0 SHALL be ignored.
REQ-015 Write addr 5 with TXEN=1 and FIFO full SHALL drop the byte and set sticky OVERRUN; a pop in the same cycle makes the FIFO not full, so the push SHALL be accepted.
REQ-016 Read addr 5 SHALL return 9'h000 (write-only).
REQ-017 Bit time SHALL be exactly 32*(PERIOD+1) clk cycles; prescaler counts 0..PERIOD and restarts at 0 on each frame start.
REQ-018 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 IDLE -> START when TXEN=1 and FIFO non-empty; FIFO head SHALL pop into the shift register on that transition; no same-cycle bypass of an empty FIFO.
REQ-020 txout SHALL go low on the clock edge after the pop, i.e. at most 2 cycles after the write that filled an empty FIFO in IDLE.
REQ-021 START drives 0 for one bit time; DATA drives 8 bits LSB first, one bit time each; STOP drives 1 for one bit time.
REQ-022 At end of STOP, if FIFO non-empty, FSM SHALL go directly to START with a pop (no idle gap); otherwise to IDLE.
REQ-023 Writing TXEN=0 SHALL, on the next edge, abort any frame, flush the FIFO, clear OVERRUN, reset the prescaler, force IDLE and drive txout=1.
REQ-024 PERIOD writes mid-frame SHALL take effect at the next prescaler wrap.

Reset
REQ-025 reset SHALL asynchronously set txout=1, PERIOD=8'h00, TXEN=0, OVERRUN=0, FIFO empty, FSM IDLE, prescaler and bit counter 0.
REQ-026 Reset asserted mid-frame SHALL truncate the frame immediately, with txout high while reset is asserted and after release.

Configuration
REQ-027 With UART_TX_PARITY_EN defined, PARITY state SHALL sit between DATA and STOP, driving even parity (XOR of the 8 data bits) for one bit time; frame is 11 bits.
REQ-028 Without UART_TX_PARITY_EN, PARITY state and logic SHALL be absent; frame is 10 bits.

Verification
REQ-029 Write PERIOD=8'h0C, read addr 4 -> dout=9'h00C.
REQ-030 TXEN=1, write 8'h39 -> txout 0,1,0,0,1,1,1,0,0,1, each 416 cycles; TXIDLE=1 afterwards; with macro, parity bit 0 precedes stop.
REQ-031 Write 8'h12, 8'hD3, 8'hB7 back-to-back -> three contiguous frames, no high gap between a stop bit and the next start bit.
REQ-032 TXEN=1, 18 back-to-back writes -> first byte in shifter, 16 queued, 18th dropped; OVERRUN=1, TXRDY=0.
REQ-033 From REQ-032, write TXEN=0 -> next cycle txout=1, OVERRUN=0, TXIDLE=1, TXRDY=1; re-enable, write 8'hA7 -> single correct frame.
REQ-034 Assert reset mid-DATA -> txout=1 immediately; after release status reads 9'h00A with TXEN=0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Register bus for the UART transmitter: write strobe, read enable, address, data in/out.
interface uart_tx_if;
  logic       wren;
  logic       rden;
  logic [2:0] addr;
  logic [7:0] din;
  logic [8:0] dout;

  modport master (
    output wren,
    output rden,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  wren,
    input  rden,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN defined); bit time 32*(PERIOD+1) clocks.
// Registers: 4=PERIOD, 5=TXDATA (write-only), 7=CTRL/STATUS.
module uart_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       txout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] A_PERIOD = 3'd4;
  localparam logic [2:0] A_TXDATA = 3'd5;
  localparam logic [2:0] A_CTRL   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t         state_reg, state_next;
  logic [7:0]     period_reg;
  logic [7:0]     period_act_reg;
  logic           txen_reg;
  logic           overrun_reg;
  logic [7:0]     presc_reg;
  logic [4:0]     tick_reg;
  logic [2:0]     bit_cnt_reg;
  logic [7:0]     data_reg;
  logic           txout_next;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    count_reg;

  logic wr_period, wr_data, wr_ctrl, flush;
  logic fifo_empty, fifo_full, bit_done;
  logic push, pop, overrun_set, tx_idle;

  assign wr_period  = bus.wren && (bus.addr == A_PERIOD);
  assign wr_data    = bus.wren && (bus.addr == A_TXDATA);
  assign wr_ctrl    = bus.wren && (bus.addr == A_CTRL);
  assign flush      = wr_ctrl && !bus.din[0];

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign bit_done   = (presc_reg == period_act_reg) && (tick_reg == 5'd31);

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push        = wr_data && txen_reg && (!fifo_full || pop);
  assign overrun_set = wr_data && txen_reg && fifo_full && !pop;
  assign tx_idle     = fifo_empty && (state_reg == S_IDLE);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    txout_next = txout;
    case (state_reg)
      S_IDLE: begin
        if (txen_reg && !fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
          txout_next = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next = S_DATA;
          txout_next = data_reg[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            txout_next = ^data_reg;
`else
            state_next = S_STOP;
            txout_next = 1'b1;
`endif
          end else begin
            txout_next = data_reg[bit_cnt_reg + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_next = S_STOP;
          txout_next = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more data is waiting.
          if (txen_reg && !fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
            txout_next = 1'b0;
          end else begin
            state_next = S_IDLE;
            txout_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        txout_next = 1'b1;
      end
    endcase
    if (flush) begin
      state_next = S_IDLE;
      pop        = 1'b0;
      txout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      txout     <= 1'b1;
    end else begin
      state_reg <= state_next;
      txout     <= txout_next;
    end
  end

  // The active period is only refreshed at a prescaler wrap or frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg      <= 8'd0;
      tick_reg       <= 5'd0;
      bit_cnt_reg    <= 3'd0;
      period_act_reg <= 8'd0;
    end else if (flush || pop || (state_reg == S_IDLE)) begin
      presc_reg      <= 8'd0;
      tick_reg       <= 5'd0;
      bit_cnt_reg    <= 3'd0;
      period_act_reg <= period_reg;
    end else begin
      if (presc_reg == period_act_reg) begin
        presc_reg      <= 8'd0;
        tick_reg       <= tick_reg + 5'd1;
        period_act_reg <= period_reg;
      end else begin
        presc_reg <= presc_reg + 8'd1;
      end
      if ((state_reg == S_DATA) && bit_done) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_reg  <= 8'h00;
      txen_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_period) begin
        period_reg <= bus.din;
      end
      if (wr_ctrl) begin
        txen_reg <= bus.din[0];
      end
      if (flush) begin
        overrun_reg <= 1'b0;
      end else if (overrun_set) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage has no reset so it maps onto block RAM; the pop is its registered read port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.din;
    end
    if (pop) begin
      data_reg <= mem[rd_ptr_reg];
    end
  end

  always_comb begin
    bus.dout = 9'h000;
    if (bus.rden) begin
      case (bus.addr)
        A_PERIOD: bus.dout = {1'b0, period_reg};
        A_CTRL:   bus.dout = {5'b00000, tx_idle, overrun_reg, !fifo_full, txen_reg};
        default:  bus.dout = 9'h000;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus queues expected bytes, a line monitor
// reconstructs each frame cycle by cycle and compares against the queued byte.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  logic txout;

  uart_tx_if bus ();

  uart_tx #(.FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txout (txout)
  );

  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  logic [7:0] sb[$];
  int         per_model = 0;
  bit         mon_en = 1'b0;
  bit         m_busy = 1'b0;

  // Line image of one frame, LSB = first bit on the wire.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic check(input bit ok, input string name, input int got, input int exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wren = 1'b1;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [8:0] v);
    bus.rden = 1'b1;
    bus.addr = a;
    #1;
    v = bus.dout;
    bus.rden = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_busy) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check(n < max_cyc, "drain_timeout", n, max_cyc);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle of a frame must carry the expected bit.
  initial begin
    int         cyc, bt, bad_idx;
    logic [10:0] exp_bits;
    logic [7:0] cur;
    bit         ok, gap_chk;
    gap_chk = 1'b0;
    cyc = 0; bt = 32; bad_idx = -1; exp_bits = '1; cur = 8'h00; ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        m_busy  = 1'b0;
        gap_chk = 1'b0;
        continue;
      end
      if (!m_busy) begin
        if (gap_chk) begin
          check(txout === 1'b0, "gap_between_frames", txout, 0);
          gap_chk = 1'b0;
        end
        if (txout === 1'b0) begin
          if (sb.size() == 0) begin
            check(1'b0, "spurious_start", 1, 0);
            cur = 8'h00;
          end else begin
            cur = sb.pop_front();
          end
          exp_bits = frame_of(cur);
          bt       = 32 * (per_model + 1);
          cyc      = 0;
          ok       = 1'b1;
          bad_idx  = -1;
          m_busy   = 1'b1;
        end
      end
      if (m_busy) begin
        if (ok && (txout !== exp_bits[cyc / bt])) begin
          ok      = 1'b0;
          bad_idx = cyc / bt;
        end
        cyc++;
        if (cyc == NBITS * bt) begin
          check(ok, $sformatf("frame_%02h_bad_bit_index", cur), bad_idx, -1);
          $display("frame byte=%02h bits=%0d bit_time=%0d ok=%0d", cur, NBITS, bt, ok);
          m_busy  = 1'b0;
          gap_chk = (sb.size() != 0);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] v;
    logic [7:0] b;
    int         lat, p, n;
    bit         stayed_high;
    logic [7:0] b2b [3];
    b2b[0] = 8'h12; b2b[1] = 8'hD3; b2b[2] = 8'hB7;

    bus.wren = 1'b0;
    bus.rden = 1'b0;
    bus.addr = 3'd0;
    bus.din  = 8'h00;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(txout === 1'b1, "reset_txout", txout, 1);
    rd(3'd7, v); check(v == 9'h00A, "reset_status", v, 9'h00A);
    rd(3'd4, v); check(v == 9'h000, "reset_period", v, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // TXDATA writes with TXEN=0 are discarded.
    wr(3'd5, 8'h55);
    stayed_high = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (txout !== 1'b1) stayed_high = 1'b0;
    end
    check(stayed_high, "txen0_write_ignored", !stayed_high, 0);
    rd(3'd7, v); check(v == 9'h00A, "txen0_status", v, 9'h00A);

    wr(3'd4, 8'h0C); per_model = 12;
    rd(3'd4, v); check(v == 9'h00C, "period_read", v, 9'h00C);
    rd(3'd5, v); check(v == 9'h000, "txdata_read", v, 0);
    bus.addr = 3'd4; bus.rden = 1'b0; #1;
    check(bus.dout == 9'h000, "rden_low_dout", bus.dout, 0);
    rd(3'd6, v); check(v == 9'h000, "unmapped_read", v, 0);
    wr(3'd7, 8'hFF);
    rd(3'd7, v); check(v == 9'h00B, "txen_on_status", v, 9'h00B);

    // Single frame 0x39 with start latency.
    sb.push_back(8'h39);
    wr(3'd5, 8'h39);
    lat = 0;
    while (txout !== 1'b0 && lat < 3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat >= 1 && lat <= 2, "start_latency", lat, 2);
    wait_done(6000);
    rd(3'd7, v); check(v == 9'h00B, "idle_after_39", v, 9'h00B);

    // Back-to-back frames.
    wr(3'd4, 8'h01); per_model = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(b2b[i]);
      wr(3'd5, b2b[i]);
    end
    wait_done(4000);
    rd(3'd7, v); check(v == 9'h00B, "idle_after_b2b", v, 9'h00B);

    // Random bursts at random small periods.
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(0, 2);
      wr(3'd4, 8'(p)); per_model = p;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        sb.push_back(b);
        wr(3'd5, b);
      end
      wait_done(20000);
      rd(3'd7, v); check(v == 9'h00B, "idle_after_random", v, 9'h00B);
    end

    // Overflow: 1 in shifter, 16 queued, 18th dropped.
    wr(3'd4, 8'h0C); per_model = 12;
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      if (i < 17) sb.push_back(b);
      wr(3'd5, b);
    end
    rd(3'd7, v); check(v == 9'h005, "overrun_status", v, 9'h005);

    // Disable aborts and flushes.
    mon_en = 1'b0;
    wr(3'd7, 8'h00);
    check(txout === 1'b1, "abort_txout", txout, 1);
    rd(3'd7, v); check(v == 9'h00A, "abort_status", v, 9'h00A);
    sb.delete();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    wr(3'd7, 8'h01);
    sb.push_back(8'hA7);
    wr(3'd5, 8'hA7);
    wait_done(6000);
    rd(3'd7, v); check(v == 9'h00B, "reenable_idle", v, 9'h00B);

    // Reset in the middle of the data bits.
    sb.push_back(8'hC5);
    wr(3'd5, 8'hC5);
    repeat (1248) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check(txout === 1'b1, "reset_mid_frame_txout", txout, 1);
    sb.delete();
    @(posedge clk);
    #1;
    check(txout === 1'b1, "reset_hold_txout", txout, 1);
    reset = 1'b0;
    per_model = 0;
    @(posedge clk);
    #1;
    check(txout === 1'b1, "reset_release_txout", txout, 1);
    rd(3'd7, v); check(v == 9'h00A, "reset_release_status", v, 9'h00A);
    rd(3'd4, v); check(v == 9'h000, "reset_release_period", v, 0);

    // Recovery after reset at PERIOD 0.
    wr(3'd7, 8'h01);
    sb.push_back(8'h3C);
    wr(3'd5, 8'h3C);
    wait_done(2000);
    rd(3'd7, v); check(v == 9'h00B, "post_reset_idle", v, 9'h00B);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
